// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - shared types and encodings for the multi-cycle RV32I control unit
package riscv_ctrl_pkg;

  // Control FSM states
  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADR   = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
    S_JAL       = 4'd10,
    S_TRAP      = 4'd11
  } state_t;

  // ALU operation codes seen by the datapath
  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_AND = 4'b0010,
    ALU_OR  = 4'b0011,
    ALU_SLT = 4'b0101,
    ALU_BAD = 4'b1111
  } alu_ctrl_t;

  // Coarse ALU request from the FSM; FUNC defers to func3/func7
  typedef enum logic [1:0] {
    ALUOP_ADD  = 2'd0,
    ALUOP_SUB  = 2'd1,
    ALUOP_FUNC = 2'd2
  } alu_op_t;

  // Opcodes handled by this core
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // func3 values of interest
  localparam logic [2:0] F3_BEQ    = 3'b000;
  localparam logic [2:0] F3_BNE    = 3'b001;
  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_SLT    = 3'b010;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_AND    = 3'b111;

  // Operand and result mux selects
  localparam logic [1:0] SRCA_PC     = 2'b00;
  localparam logic [1:0] SRCA_OLDPC  = 2'b01;
  localparam logic [1:0] SRCA_RS1    = 2'b10;
  localparam logic [1:0] SRCB_RS2    = 2'b00;
  localparam logic [1:0] SRCB_IMM    = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;
  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_MEMDATA = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;
  localparam logic       ADR_PC      = 1'b0;
  localparam logic       ADR_ALUOUT  = 1'b1;

  // Immediate formats
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;

  // Trap cause codes
  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  // Immediate format implied by the opcode; unknown opcodes fall back to I
  function automatic logic [2:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// rtl/multicycle_control_alu_decoder.sv - maps alu_op/func3/func7 to an ALU control code
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  alu_op_t     alu_op,
  input  logic [2:0]  func3,
  input  logic        func7_b5,
  input  logic        op_b5,
  output alu_ctrl_t   alu_control,
  output logic        bad
);

  // Resolve the ALU operation; FUNC uses func3, with SUB only for register-register ops
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNC: begin
        case (func3)
          F3_ADDSUB: alu_control = (op_b5 && func7_b5) ? ALU_SUB : ALU_ADD;
          F3_SLT:    alu_control = ALU_SLT;
          F3_OR:     alu_control = ALU_OR;
          F3_AND:    alu_control = ALU_AND;
          default:   alu_control = ALU_BAD;
        endcase
      end
      default: alu_control = ALU_BAD;
    endcase
  end

  assign bad = (alu_control == ALU_BAD);

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle RV32I control FSM with memory handshake, timeout and traps
module multicycle_control
  import riscv_ctrl_pkg::*;
#(
  parameter int WAIT_STATES_EN = 1,
  parameter int MEM_TIMEOUT    = 0,
  parameter int CNT_W          = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       adr_src,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] imm_source,
  output logic [3:0] alu_control,
  output logic       trap,
  output logic [1:0] trap_cause
);

  localparam bit               TMO_EN   = (MEM_TIMEOUT > 0);
  localparam logic [CNT_W-1:0] TMO_LAST = TMO_EN ? CNT_W'(MEM_TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             trap_q, trap_d;
  logic [1:0]       trap_cause_q, trap_cause_d;

  alu_op_t   alu_op;
  alu_ctrl_t alu_ctrl;
  logic      alu_bad;
  logic      mem_rdy;
  logic      in_mem_state;
  logic      stalled;
  logic      timeout_hit;
  logic      unused_func7;

  // Without wait states every access completes in one cycle
  assign mem_rdy      = (WAIT_STATES_EN != 0) ? mem_ready : 1'b1;
  assign in_mem_state = (state_q == S_FETCH) || (state_q == S_MEM_READ) || (state_q == S_MEM_WRITE);
  assign stalled      = in_mem_state && !mem_rdy;
  // A ready on the last allowed cycle still advances normally because timeout needs !mem_rdy
  assign timeout_hit  = TMO_EN && stalled && (stall_cnt_q == TMO_LAST);

  // Only func7[5] matters to this subset
  assign unused_func7 = ^{func7[6], func7[4:0]};

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .func3       (func3),
    .func7_b5    (func7[5]),
    .op_b5       (op[5]),
    .alu_control (alu_ctrl),
    .bad         (alu_bad)
  );

  // State, stall counter and sticky trap registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_FETCH;
      stall_cnt_q  <= '0;
      trap_q       <= 1'b0;
      trap_cause_q <= CAUSE_NONE;
    end else begin
      state_q      <= state_d;
      stall_cnt_q  <= stall_cnt_d;
      trap_q       <= trap_d;
      trap_cause_q <= trap_cause_d;
    end
  end

  // Next state, trap capture and stall counting
  always_comb begin
    state_d      = state_q;
    trap_cause_d = trap_cause_q;
    stall_cnt_d  = stall_cnt_q;
    case (state_q)
      S_FETCH: begin
        if (mem_rdy) begin
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          state_d      = S_TRAP;
          trap_cause_d = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEM_ADR;
          OP_REG:            state_d = S_EXEC_R;
          OP_IMM:            state_d = S_EXEC_I;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          default: begin
            state_d      = S_TRAP;
            trap_cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_MEM_ADR:  state_d = op[5] ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ: begin
        if (mem_rdy) begin
          state_d = S_MEM_WB;
        end else if (timeout_hit) begin
          state_d      = S_TRAP;
          trap_cause_d = CAUSE_TIMEOUT;
        end
      end
      S_MEM_WB:   state_d = S_FETCH;
      S_MEM_WRITE: begin
        if (mem_rdy) begin
          state_d = S_FETCH;
        end else if (timeout_hit) begin
          state_d      = S_TRAP;
          trap_cause_d = CAUSE_TIMEOUT;
        end
      end
      S_EXEC_R, S_EXEC_I: begin
        if (alu_bad) begin
          state_d      = S_TRAP;
          trap_cause_d = CAUSE_ILLEGAL;
        end else begin
          state_d = S_ALU_WB;
        end
      end
      S_ALU_WB:   state_d = S_FETCH;
      S_BRANCH: begin
        if ((func3 == F3_BEQ) || (func3 == F3_BNE)) begin
          state_d = S_FETCH;
        end else begin
          state_d      = S_TRAP;
          trap_cause_d = CAUSE_ILLEGAL;
        end
      end
      S_JAL:      state_d = S_ALU_WB;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_FETCH;
    endcase

    trap_d = trap_q || (state_d == S_TRAP);

    if (state_d != state_q) begin
      stall_cnt_d = '0;
    end else if (stalled && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // Moore datapath controls from state, plus the fetch/branch strobes that qualify on inputs
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    adr_src    = ADR_PC;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        mem_read   = 1'b1;
        adr_src    = ADR_PC;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        ir_write   = mem_rdy;
        pc_write   = mem_rdy;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      S_MEM_ADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      S_MEM_READ: begin
        adr_src  = ADR_ALUOUT;
        mem_read = 1'b1;
      end
      S_MEM_WB: begin
        result_src = RES_MEMDATA;
        reg_write  = 1'b1;
      end
      S_MEM_WRITE: begin
        adr_src   = ADR_ALUOUT;
        mem_write = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        alu_op    = ALUOP_FUNC;
      end
      S_EXEC_I: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNC;
      end
      S_ALU_WB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_SUB;
        result_src = RES_ALUOUT;
        if (func3 == F3_BEQ) begin
          pc_write = alu_zero;
        end else if (func3 == F3_BNE) begin
          pc_write = !alu_zero;
        end
      end
      S_JAL: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALUOUT;
        pc_write   = 1'b1;
      end
      default: begin
      end
    endcase

    // Reset must not let a half-finished access or write leak out
    if (rst) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
    end
  end

  assign alu_control = alu_ctrl;
  assign imm_source  = imm_src_of(op);
  assign trap        = trap_q;
  assign trap_cause  = trap_cause_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - self-checking bench for multicycle_control
module tb_multicycle_control;

  localparam int TMO   = 4;
  localparam int K_LW  = 0;
  localparam int K_SW  = 1;
  localparam int K_R   = 2;
  localparam int K_I   = 3;
  localparam int K_BR  = 4;
  localparam int K_JAL = 5;
  localparam int K_ILL = 6;

  logic       clk;
  logic       rst;
  logic [6:0] op;
  logic [2:0] func3;
  logic [6:0] func7;
  logic       alu_zero;
  logic       mem_ready;
  logic       pc_write, ir_write, adr_src, mem_read, mem_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] imm_source;
  logic [3:0] alu_control;
  logic       trap;
  logic [1:0] trap_cause;

  int checks   = 0;
  int failures = 0;

  logic [21:0] exp_q[$];
  logic        rdy_q[$];
  logic        zero_q[$];
  logic [2:0]  m_imm;
  logic        m_dead;
  logic [21:0] obs;

  multicycle_control #(
    .WAIT_STATES_EN (1),
    .MEM_TIMEOUT    (TMO),
    .CNT_W          (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .op          (op),
    .func3       (func3),
    .func7       (func7),
    .alu_zero    (alu_zero),
    .mem_ready   (mem_ready),
    .pc_write    (pc_write),
    .ir_write    (ir_write),
    .adr_src     (adr_src),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .reg_write   (reg_write),
    .result_src  (result_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .imm_source  (imm_source),
    .alu_control (alu_control),
    .trap        (trap),
    .trap_cause  (trap_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {pc_write, ir_write, adr_src, mem_read, mem_write, reg_write,
                result_src, alu_src_a, alu_src_b, alu_control, trap, trap_cause, imm_source};

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  // Expected output vector for a non-trapped cycle
  function automatic logic [21:0] ov(input logic pcw, input logic irw, input logic adr,
                                     input logic mr, input logic mw, input logic rw,
                                     input logic [1:0] rs, input logic [1:0] a,
                                     input logic [1:0] b, input logic [3:0] alu);
    return {pcw, irw, adr, mr, mw, rw, rs, a, b, alu, 1'b0, 2'b00, m_imm};
  endfunction

  // Expected output vector while halted
  function automatic logic [21:0] tv(input logic [1:0] cause);
    return {6'b000000, 2'b00, 2'b00, 2'b00, 4'b0000, 1'b1, cause, m_imm};
  endfunction

  function automatic logic [2:0] exp_imm(input logic [6:0] o);
    if (o == 7'b0000011 || o == 7'b0010011) return 3'b000;
    if (o == 7'b0100011) return 3'b001;
    if (o == 7'b1100011) return 3'b010;
    if (o == 7'b1101111) return 3'b011;
    return 3'b000;
  endfunction

  function automatic logic [3:0] func_alu(input logic [2:0] f3, input logic want_sub);
    case (f3)
      3'b000:  return want_sub ? 4'b0001 : 4'b0000;
      3'b010:  return 4'b0101;
      3'b110:  return 4'b0011;
      3'b111:  return 4'b0010;
      default: return 4'b1111;
    endcase
  endfunction

  task automatic emit(input logic [21:0] e, input logic r, input logic z);
    exp_q.push_back(e);
    rdy_q.push_back(r);
    zero_q.push_back(z);
  endtask

  task automatic go_trap(input logic [1:0] cause);
    m_dead = 1'b1;
    repeat (3) emit(tv(cause), rb(), rb());
  endtask

  // A memory-access phase: 'stall' not-ready cycles then a ready cycle, unless the timeout fires
  task automatic mem_phase(input int stall, input logic [21:0] idle, input logic [21:0] done,
                           output logic to);
    to = 1'b0;
    for (int s = 0; s < stall; s++) begin
      emit(idle, 1'b0, rb());
      if (s == TMO - 1) begin
        to = 1'b1;
        return;
      end
    end
    emit(done, 1'b1, rb());
  endtask

  // Expected cycle-by-cycle outputs of one instruction, from the instruction-level rules
  task automatic model_instr(input int kind, input logic [2:0] f3, input logic f7b5,
                             input logic z, input int fst, input int mst);
    logic       to;
    logic [3:0] fa;
    logic       bpc;
    m_dead = 1'b0;
    mem_phase(fst, ov(0,0,0,1,0,0,2'b10,2'b00,2'b10,4'h0),
                   ov(1,1,0,1,0,0,2'b10,2'b00,2'b10,4'h0), to);
    if (to) begin
      go_trap(2'b10);
      return;
    end
    emit(ov(0,0,0,0,0,0,2'b00,2'b01,2'b01,4'h0), rb(), rb());
    case (kind)
      K_LW: begin
        emit(ov(0,0,0,0,0,0,2'b00,2'b10,2'b01,4'h0), rb(), rb());
        mem_phase(mst, ov(0,0,1,1,0,0,2'b00,2'b00,2'b00,4'h0),
                       ov(0,0,1,1,0,0,2'b00,2'b00,2'b00,4'h0), to);
        if (to) go_trap(2'b10);
        else emit(ov(0,0,0,0,0,1,2'b01,2'b00,2'b00,4'h0), rb(), rb());
      end
      K_SW: begin
        emit(ov(0,0,0,0,0,0,2'b00,2'b10,2'b01,4'h0), rb(), rb());
        mem_phase(mst, ov(0,0,1,0,1,0,2'b00,2'b00,2'b00,4'h0),
                       ov(0,0,1,0,1,0,2'b00,2'b00,2'b00,4'h0), to);
        if (to) go_trap(2'b10);
      end
      K_R, K_I: begin
        fa = func_alu(f3, (kind == K_R) && f7b5);
        emit(ov(0,0,0,0,0,0,2'b00,2'b10,(kind == K_R) ? 2'b00 : 2'b01,fa), rb(), rb());
        if (fa == 4'b1111) go_trap(2'b01);
        else emit(ov(0,0,0,0,0,1,2'b00,2'b00,2'b00,4'h0), rb(), rb());
      end
      K_BR: begin
        bpc = (f3 == 3'b000) ? z : (f3 == 3'b001) ? !z : 1'b0;
        emit(ov(bpc,0,0,0,0,0,2'b00,2'b10,2'b00,4'h1), rb(), z);
        if (f3 > 3'b001) go_trap(2'b01);
      end
      K_JAL: begin
        emit(ov(1,0,0,0,0,0,2'b00,2'b01,2'b10,4'h0), rb(), rb());
        emit(ov(0,0,0,0,0,1,2'b00,2'b00,2'b00,4'h0), rb(), rb());
      end
      default: go_trap(2'b01);
    endcase
  endtask

  task automatic check(input string tag, input logic [21:0] got, input logic [21:0] want);
    checks++;
    assert (got === want)
    else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, got, want);
    end
  endtask

  // Apply the queued stimulus, comparing outputs at each falling edge
  task automatic run_queue(input string tag);
    while (exp_q.size() > 0) begin
      mem_ready = rdy_q.pop_front();
      alu_zero  = zero_q.pop_front();
      @(negedge clk);
      check(tag, obs, exp_q.pop_front());
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input string tag);
    rst       = 1'b1;
    mem_ready = rb();
    alu_zero  = rb();
    @(negedge clk);
    checks++;
    assert ({pc_write, ir_write, reg_write, mem_read, mem_write} === 5'b00000)
    else begin
      failures++;
      $error("FAIL %s_rst_enables observed=%b expected=00000", tag,
             {pc_write, ir_write, reg_write, mem_read, mem_write});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    assert ({trap, trap_cause} === 3'b000)
    else begin
      failures++;
      $error("FAIL %s_rst_trap observed=%b expected=000", tag, {trap, trap_cause});
    end
  endtask

  task automatic set_instr(input int kind, input logic [2:0] f3, input logic f7b5);
    case (kind)
      K_LW:    op = 7'b0000011;
      K_SW:    op = 7'b0100011;
      K_R:     op = 7'b0110011;
      K_I:     op = 7'b0010011;
      K_BR:    op = 7'b1100011;
      K_JAL:   op = 7'b1101111;
      default: begin
        case ($urandom_range(0, 3))
          0:       op = 7'b0110111;
          1:       op = 7'b0000000;
          2:       op = 7'b1110011;
          default: op = 7'b1100111;
        endcase
      end
    endcase
    func3 = f3;
    func7 = {1'b0, f7b5, 5'($urandom)};
    m_imm = exp_imm(op);
  endtask

  task automatic do_instr(input string tag, input int kind, input logic [2:0] f3,
                          input logic f7b5, input logic z, input int fst, input int mst);
    set_instr(kind, f3, f7b5);
    model_instr(kind, f3, f7b5, z, fst, mst);
    run_queue(tag);
    if (m_dead) do_reset({tag, "_post"});
  endtask

  initial begin
    int         kind;
    logic [2:0] f3;
    int         fst;
    int         mst;

    rst       = 1'b1;
    op        = 7'b0;
    func3     = 3'b0;
    func7     = 7'b0;
    alu_zero  = 1'b0;
    mem_ready = 1'b0;
    m_dead    = 1'b0;
    m_imm     = 3'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset("reset");

    do_instr("t2_lw", K_LW, 3'b010, 1'b0, 1'b0, 0, 0);

    set_instr(K_LW, 3'b010, 1'b0);
    emit(ov(1,1,0,1,0,0,2'b10,2'b00,2'b10,4'h0), 1'b1, 1'b0);
    emit(ov(0,0,0,0,0,0,2'b00,2'b01,2'b01,4'h0), 1'b0, 1'b0);
    emit(ov(0,0,0,0,0,0,2'b00,2'b10,2'b01,4'h0), 1'b0, 1'b0);
    emit(ov(0,0,1,1,0,0,2'b00,2'b00,2'b00,4'h0), 1'b0, 1'b0);
    run_queue("t1_pre");
    do_reset("t1");
    do_instr("t1_after", K_LW, 3'b010, 1'b0, 1'b0, 0, 0);

    do_instr("t3_sw", K_SW, 3'b010, 1'b0, 1'b0, 0, 3);
    do_instr("t4_beq", K_BR, 3'b000, 1'b0, 1'b1, 0, 0);
    do_instr("t4_bne", K_BR, 3'b001, 1'b0, 1'b1, 0, 0);
    do_instr("t5_sub", K_R, 3'b000, 1'b1, 1'b0, 0, 0);
    do_instr("t5_bad", K_R, 3'b001, 1'b1, 1'b0, 0, 0);
    do_instr("t5_addi", K_I, 3'b000, 1'b1, 1'b0, 0, 0);
    do_instr("t6_tmo", K_R, 3'b000, 1'b0, 1'b0, 4, 0);
    do_instr("t6_edge", K_R, 3'b000, 1'b0, 1'b0, 3, 0);
    do_instr("lw_tmo", K_LW, 3'b010, 1'b0, 1'b0, 1, 4);
    do_instr("sw_tmo", K_SW, 3'b010, 1'b0, 1'b0, 2, 4);
    do_instr("jal", K_JAL, 3'b000, 1'b0, 1'b0, 0, 0);
    do_instr("illegal", K_ILL, 3'b000, 1'b0, 1'b0, 0, 0);
    do_instr("br_bad", K_BR, 3'b100, 1'b0, 1'b1, 0, 0);

    for (int i = 0; i < 200; i++) begin
      kind = $urandom_range(0, 6);
      if (kind == K_BR && $urandom_range(0, 3) != 0) f3 = {2'b00, rb()};
      else f3 = 3'($urandom);
      fst = ($urandom_range(0, 9) == 0) ? 4 : $urandom_range(0, 3);
      mst = ($urandom_range(0, 9) == 0) ? 4 : $urandom_range(0, 3);
      do_instr("rand", kind, f3, rb(), rb(), fst, mst);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
